// File: rtl/lc4_arith_pkg.sv
// Shared LC4 arithmetic definitions: ALU_CTL opcodes, datapath width and the
// sequencer states of the iterative multiply/divide unit.
package lc4_arith_pkg;

  localparam int unsigned WIDTH = 16;

  localparam logic [15:0] OP_MUL = 16'd1;
  localparam logic [15:0] OP_DIV = 16'd3;
  localparam logic [15:0] OP_MOD = 16'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Illegal opcodes and division by zero bypass the iteration entirely.
  function automatic logic op_skips_run(input logic [15:0] op, input logic [15:0] b);
    logic is_div;
    is_div = (op == OP_DIV) || (op == OP_MOD);
    return !((op == OP_MUL) || (is_div && (b != '0)));
  endfunction

endpackage

// File: rtl/lc4_muldiv_step.sv
// One combinational iteration of the shared multiply (shift-add) and
// restoring-divide (MSB first) datapath.
module lc4_muldiv_step
  import lc4_arith_pkg::*;
#(
  parameter  int unsigned WIDTH = lc4_arith_pkg::WIDTH,
  localparam int unsigned CW    = $clog2(WIDTH)
) (
  input  logic [15:0]      op,
  input  logic [CW-1:0]    count,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] quo,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH-1:0] addend;
  logic [CW-1:0]    msb_idx;
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] divisor;

  always_comb begin
    acc_next = acc;
    quo_next = quo;
    addend   = a << count;
    msb_idx  = CW'(WIDTH - 1) - count;
    rem_sh   = {acc, a[msb_idx]};
    divisor  = {2'b00, b};

    if (op == OP_MUL) begin
      if (b[count]) begin
        acc_next = {1'b0, acc[WIDTH-1:0] + addend};
      end
    end else begin
      // Quotient bits enter at the LSB; after the last step bit 15-count sits in place.
      if (rem_sh >= divisor) begin
        acc_next = (WIDTH + 1)'(rem_sh - divisor);
        quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = (WIDTH + 1)'(rem_sh);
        quo_next = {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/lc4_muldiv_seq.sv
// Iterative LC4 multiply/divide unit: valid/ready request, 16 one-bit
// iterations, valid/ready response holding the registered result.
module lc4_muldiv_seq
  import lc4_arith_pkg::*;
#(
  parameter int unsigned WIDTH = lc4_arith_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [15:0]      i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [15:0]      op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   acc_q, acc_next;
  logic [WIDTH-1:0] quo_q, quo_next;
  logic [WIDTH-1:0] result_q;
  logic             accept, last_iter;

  assign accept    = i_req_valid && (state_q == IDLE);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  lc4_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_q),
    .count    (cnt_q),
    .a        (a_q),
    .b        (b_q),
    .acc      (acc_q),
    .quo      (quo_q),
    .acc_next (acc_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = op_skips_run(i_op, 16'(i_b)) ? DONE : RUN;
      RUN:  if (last_iter) state_d = DONE;
      DONE: if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (state_q == IDLE);
    o_rsp_valid = (state_q == DONE);
    o_busy      = (state_q == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= i_op;
            a_q   <= i_a;
            b_q   <= i_b;
            cnt_q <= '0;
            acc_q <= '0;
            quo_q <= '0;
            if (op_skips_run(i_op, 16'(i_b))) result_q <= '0;
          end
        end
        RUN: begin
          acc_q <= acc_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            if (op_q == OP_MUL)      result_q <= acc_next[WIDTH-1:0];
            else if (op_q == OP_DIV) result_q <= quo_next;
            else                     result_q <= acc_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_result = result_q;

endmodule

// File: tb/tb_lc4_muldiv_seq.sv
// Directed self-checking bench for lc4_muldiv_seq with a result scoreboard.
module tb_lc4_muldiv_seq;
  import lc4_arith_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [15:0] i_op;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [15:0] o_result;
  logic        o_busy;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] held;
  int          lat;
  logic        busy_seen;

  lc4_muldiv_seq #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_op        (i_op),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_result    (o_result),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge and return #1 after its accept edge.
  task automatic send(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp);
    int n;
    @(negedge clk);
    i_op = op; i_a = a; i_b = b; i_req_valid = 1'b1;
    exp_q.push_back(exp);
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", (n < 50), 1);
    @(posedge clk);
    #1 i_req_valid = 1'b0;
  endtask

  // lat = number of edges after the accept edge when o_rsp_valid is first seen.
  task automatic wait_rsp(input logic at_neg, output int m, output logic bseen);
    m = 0;
    bseen = 1'b0;
    if (!at_neg) @(negedge clk);
    bseen = o_busy;
    while (!o_rsp_valid && m < 40) begin
      @(posedge clk);
      m++;
      @(negedge clk);
      if (o_busy) bseen = 1'b1;
    end
    chk("rsp_wait", (m < 40), 1);
  endtask

  // Compare against the scoreboard head while valid; handshake at next edge.
  task automatic take(input string tag);
    logic [15:0] e;
    chk("sb_nonempty", (exp_q.size() > 0), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    chk(tag, o_result, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; i_req_valid = 1'b0; i_op = '0; i_a = '0; i_b = '0; i_rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", o_req_ready, 1);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_result", o_result, 0);
    rst_n = 1'b1;

    // MUL basic with latency and ready-return checks
    send(OP_MUL, 16'd300, 16'd7, 16'd2100);
    wait_rsp(1'b0, lat, busy_seen);
    chk("mul_latency", lat, 16);
    chk("mul_busy_seen", busy_seen, 1);
    take("mul_300x7");
    @(negedge clk);
    chk("mul_ready_again", o_req_ready, 1);

    send(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001);
    wait_rsp(1'b0, lat, busy_seen);
    take("mul_overflow");

    send(OP_DIV, 16'd1000, 16'd7, 16'd142);
    wait_rsp(1'b0, lat, busy_seen);
    chk("div_latency", lat, 16);
    take("div_1000_7");
    send(OP_MOD, 16'd1000, 16'd7, 16'd6);
    wait_rsp(1'b0, lat, busy_seen);
    take("mod_1000_7");
    send(OP_DIV, 16'hFFFF, 16'd1, 16'hFFFF);
    wait_rsp(1'b0, lat, busy_seen);
    take("div_ffff_1");
    send(OP_MOD, 16'hFFFF, 16'd1, 16'd0);
    wait_rsp(1'b0, lat, busy_seen);
    take("mod_ffff_1");
    send(OP_MOD, 16'd40000, 16'd65535, 16'd40000);
    wait_rsp(1'b0, lat, busy_seen);
    take("mod_small_big");

    // Skipped operations go straight to DONE: valid in the cycle after accept
    send(OP_DIV, 16'd5, 16'd0, 16'd0);
    wait_rsp(1'b0, lat, busy_seen);
    chk("dbz_latency", lat, 0);
    chk("dbz_no_busy", busy_seen, 0);
    take("dbz_result");
    send(16'd9, 16'd5, 16'd3, 16'd0);
    wait_rsp(1'b0, lat, busy_seen);
    chk("illegal_latency", lat, 0);
    chk("illegal_no_busy", busy_seen, 0);
    take("illegal_result");

    // Backpressure: result held, inputs ignored, no accept while DONE
    i_rsp_ready = 1'b0;
    send(OP_MUL, 16'd123, 16'd45, 16'd5535);
    wait_rsp(1'b0, lat, busy_seen);
    held = o_result;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 i_a = 16'($urandom); i_b = 16'($urandom); i_op = OP_MUL; i_req_valid = i[0];
      @(negedge clk);
      chk("bp_result_stable", o_result, held);
      chk("bp_valid_held", o_rsp_valid, 1);
      chk("bp_no_accept", o_req_ready, 0);
    end
    i_op = OP_MUL; i_a = 16'd5; i_b = 16'd6; i_req_valid = 1'b1;
    exp_q.push_back(16'd30);
    i_rsp_ready = 1'b1;
    take("bp_result");
    @(negedge clk);
    chk("bp_bubble_ready", o_req_ready, 1);
    chk("bp_bubble_busy", o_busy, 0);
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(negedge clk);
    chk("bp_accept_after", o_busy, 1);
    wait_rsp(1'b1, lat, busy_seen);
    chk("bp_next_latency", lat, 16);
    take("bp_next_5x6");

    // Reset in the middle of a divide
    send(OP_DIV, 16'd1000, 16'd7, 16'd142);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", o_req_ready, 1);
    chk("mid_rst_rsp_valid", o_rsp_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_result", o_result, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_response", o_rsp_valid, 0);
    send(OP_MUL, 16'd3, 16'd4, 16'd12);
    wait_rsp(1'b0, lat, busy_seen);
    take("post_rst_3x4");
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
